// File: rtl/ibex_irq_gen_pkg.sv
// Shared types and register map for the interrupt source peripheral.
// Contents:
//   irqs_t        - core interrupt bundle {software, timer, external, fast[14:0]}
//   IRQGEN_*      - byte offsets of the memory-mapped registers
//   reg_sel_e     - decoded register select
//   irqgen_decode - byte offset to register select
package ibex_irq_gen_pkg;

    localparam int unsigned IRQGEN_NUM_FAST = 15;

    typedef struct packed {
        logic                       irq_software;
        logic                       irq_timer;
        logic                       irq_external;
        logic [IRQGEN_NUM_FAST-1:0] irq_fast;
    } irqs_t;

    localparam logic [31:0] IRQGEN_MSIP_OFFSET        = 32'h00;
    localparam logic [31:0] IRQGEN_CTRL_OFFSET        = 32'h04;
    localparam logic [31:0] IRQGEN_MTIME_LO_OFFSET    = 32'h08;
    localparam logic [31:0] IRQGEN_MTIME_HI_OFFSET    = 32'h0C;
    localparam logic [31:0] IRQGEN_MTIMECMP_LO_OFFSET = 32'h10;
    localparam logic [31:0] IRQGEN_MTIMECMP_HI_OFFSET = 32'h14;
    localparam logic [31:0] IRQGEN_FAST_PEND_OFFSET   = 32'h18;
    localparam logic [31:0] IRQGEN_FAST_EDGE_OFFSET   = 32'h1C;
    localparam logic [31:0] IRQGEN_FAST_EN_OFFSET     = 32'h20;
    localparam logic [31:0] IRQGEN_NMI_OFFSET         = 32'h24;

    typedef enum logic [3:0] {
        REG_MSIP,
        REG_CTRL,
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_FAST_PEND,
        REG_FAST_EDGE,
        REG_FAST_EN,
        REG_NMI,
        REG_NONE
    } reg_sel_e;

    // Map a word-aligned byte offset to a register select; REG_NONE if unmapped.
    function automatic reg_sel_e irqgen_decode(input logic [31:0] offset);
        reg_sel_e sel;
        sel = REG_NONE;
        case (offset)
            IRQGEN_MSIP_OFFSET:        sel = REG_MSIP;
            IRQGEN_CTRL_OFFSET:        sel = REG_CTRL;
            IRQGEN_MTIME_LO_OFFSET:    sel = REG_MTIME_LO;
            IRQGEN_MTIME_HI_OFFSET:    sel = REG_MTIME_HI;
            IRQGEN_MTIMECMP_LO_OFFSET: sel = REG_CMP_LO;
            IRQGEN_MTIMECMP_HI_OFFSET: sel = REG_CMP_HI;
            IRQGEN_FAST_PEND_OFFSET:   sel = REG_FAST_PEND;
            IRQGEN_FAST_EDGE_OFFSET:   sel = REG_FAST_EDGE;
            IRQGEN_FAST_EN_OFFSET:     sel = REG_FAST_EN;
            IRQGEN_NMI_OFFSET:         sel = REG_NMI;
            default:                   sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ibex_irq_gen_timer.sv
// 64-bit mtime / mtimecmp timer with independent 32-bit half writes.
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_tick, i_timer_en   increment strobe and enable
//   i_wdata              bus write data
//   i_wr_mtime_lo/hi     write strobes for mtime halves
//   i_wr_cmp_lo/hi       write strobes for mtimecmp halves
//   o_mtime, o_mtimecmp  current register values
//   o_timer_hit_c        combinational mtime >= mtimecmp
module ibex_irq_gen_timer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tick,
    input  logic        i_timer_en,
    input  logic [31:0] i_wdata,
    input  logic        i_wr_mtime_lo,
    input  logic        i_wr_mtime_hi,
    input  logic        i_wr_cmp_lo,
    input  logic        i_wr_cmp_hi,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_timer_hit_c
);

    localparam int unsigned TimerW = 64;

    logic [TimerW-1:0] r_mtime;
    logic [TimerW-1:0] r_mtimecmp;

    // A bus write to either half suppresses the increment for that cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mtime <= '0;
        end else if (i_wr_mtime_lo) begin
            r_mtime[31:0] <= i_wdata;
        end else if (i_wr_mtime_hi) begin
            r_mtime[63:32] <= i_wdata;
        end else if (i_tick && i_timer_en) begin
            r_mtime <= r_mtime + TimerW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mtimecmp <= '1;
        end else begin
            if (i_wr_cmp_lo) begin
                r_mtimecmp[31:0] <= i_wdata;
            end
            if (i_wr_cmp_hi) begin
                r_mtimecmp[63:32] <= i_wdata;
            end
        end
    end

    assign o_mtime       = r_mtime;
    assign o_mtimecmp    = r_mtimecmp;
    assign o_timer_hit_c = (r_mtime >= r_mtimecmp);

endmodule

// File: rtl/ibex_irq_gen.sv
// Memory-mapped interrupt source on the data bus, driving the core's irqs_t inputs.
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   data_req_i/gnt_o          request / grant (grant = request, no stall)
//   data_we_i, data_be_i      write enable, byte enables
//   data_addr_i, data_wdata_i address (low RegAddrW bits decoded), write data
//   data_rvalid_o/rdata_o/err_o  registered response, one cycle after grant
//   tick_i                    timer increment strobe
//   irq_ext_i                 external interrupt level
//   irq_fast_src_i            fast interrupt sources
//   irq_nm_src_i              NMI source
//   irqs_o, irq_nm_o          registered interrupt outputs
module ibex_irq_gen
    import ibex_irq_gen_pkg::*;
#(
    parameter int unsigned RegAddrW    = 6,
    parameter logic        TimerEnRst  = 1'b0,
    parameter logic [14:0] FastEdgeRst = 15'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        tick_i,
    input  logic        irq_ext_i,
    input  logic [14:0] irq_fast_src_i,
    input  logic        irq_nm_src_i,
    output irqs_t       irqs_o,
    output logic        irq_nm_o
);

    localparam int unsigned FastW = IRQGEN_NUM_FAST;

    reg_sel_e          w_sel;
    logic              w_err;
    logic              w_wr;
    logic [31:0]       w_rdata;
    logic              w_unused;

    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              r_msip;
    logic              r_timer_en;
    logic [FastW-1:0]  r_fast_pend;
    logic [FastW-1:0]  r_fast_edge;
    logic [FastW-1:0]  r_fast_en;
    logic [FastW-1:0]  r_fast_src_q;
    logic              r_nmi;
    logic              r_nm_src_q;
    irqs_t             r_irqs;
    logic              r_irq_nm;

    logic [63:0]       w_mtime;
    logic [63:0]       w_mtimecmp;
    logic              w_timer_hit;

    logic [FastW-1:0]  w_fast_rise;
    logic [FastW-1:0]  w_fast_clr;
    logic [FastW-1:0]  w_fast_pend_d;
    logic              w_nmi_d;

    // Address bits above the decoded window and the byte lane are ignored.
    assign w_unused = ^{data_addr_i[31:RegAddrW], data_addr_i[1:0]};

    assign w_sel = irqgen_decode(32'({data_addr_i[RegAddrW-1:2], 2'b00}));
    assign w_err = (w_sel == REG_NONE) || (data_we_i && (data_be_i != 4'hF));
    assign w_wr  = data_req_i && data_we_i && !w_err;

    assign data_gnt_o = data_req_i;

    // Read mux; unused upper bits read as zero.
    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_MSIP:      w_rdata = {31'd0, r_msip};
            REG_CTRL:      w_rdata = {31'd0, r_timer_en};
            REG_MTIME_LO:  w_rdata = w_mtime[31:0];
            REG_MTIME_HI:  w_rdata = w_mtime[63:32];
            REG_CMP_LO:    w_rdata = w_mtimecmp[31:0];
            REG_CMP_HI:    w_rdata = w_mtimecmp[63:32];
            REG_FAST_PEND: w_rdata = {17'd0, r_fast_pend};
            REG_FAST_EDGE: w_rdata = {17'd0, r_fast_edge};
            REG_FAST_EN:   w_rdata = {17'd0, r_fast_en};
            REG_NMI:       w_rdata = {31'd0, r_nmi};
            default:       w_rdata = '0;
        endcase
    end

    // Response register: one response per accepted request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= data_req_i;
            r_err    <= data_req_i && w_err;
            r_rdata  <= (data_req_i && !data_we_i && !w_err) ? w_rdata : '0;
        end
    end

    assign data_rvalid_o = r_rvalid;
    assign data_rdata_o  = r_rdata;
    assign data_err_o    = r_err;

    ibex_irq_gen_timer u_timer (
        .i_clk         (clk_i),
        .i_rst_n       (rst_ni),
        .i_tick        (tick_i),
        .i_timer_en    (r_timer_en),
        .i_wdata       (data_wdata_i),
        .i_wr_mtime_lo (w_wr && (w_sel == REG_MTIME_LO)),
        .i_wr_mtime_hi (w_wr && (w_sel == REG_MTIME_HI)),
        .i_wr_cmp_lo   (w_wr && (w_sel == REG_CMP_LO)),
        .i_wr_cmp_hi   (w_wr && (w_sel == REG_CMP_HI)),
        .o_mtime       (w_mtime),
        .o_mtimecmp    (w_mtimecmp),
        .o_timer_hit_c (w_timer_hit)
    );

    // Edge-mode bits: a new rising edge beats a same-cycle W1C.
    // Level-mode bits track the source and ignore W1C.
    assign w_fast_rise   = irq_fast_src_i & ~r_fast_src_q;
    assign w_fast_clr    = (w_wr && (w_sel == REG_FAST_PEND)) ? data_wdata_i[FastW-1:0] : '0;
    assign w_fast_pend_d = (r_fast_edge & ((r_fast_pend & ~w_fast_clr) | w_fast_rise))
                         | (~r_fast_edge & irq_fast_src_i);

    assign w_nmi_d = (r_nmi && !(w_wr && (w_sel == REG_NMI) && data_wdata_i[0]))
                   || (irq_nm_src_i && !r_nm_src_q);

    // Software-visible control registers and source history.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_msip       <= 1'b0;
            r_timer_en   <= TimerEnRst;
            r_fast_pend  <= '0;
            r_fast_edge  <= FastEdgeRst;
            r_fast_en    <= '0;
            r_fast_src_q <= '0;
            r_nmi        <= 1'b0;
            r_nm_src_q   <= 1'b0;
        end else begin
            if (w_wr && (w_sel == REG_MSIP)) begin
                r_msip <= data_wdata_i[0];
            end
            if (w_wr && (w_sel == REG_CTRL)) begin
                r_timer_en <= data_wdata_i[0];
            end
            if (w_wr && (w_sel == REG_FAST_EDGE)) begin
                r_fast_edge <= data_wdata_i[FastW-1:0];
            end
            if (w_wr && (w_sel == REG_FAST_EN)) begin
                r_fast_en <= data_wdata_i[FastW-1:0];
            end
            r_fast_pend  <= w_fast_pend_d;
            r_fast_src_q <= irq_fast_src_i;
            r_nmi        <= w_nmi_d;
            r_nm_src_q   <= irq_nm_src_i;
        end
    end

    // Registered interrupt outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_irqs   <= '0;
            r_irq_nm <= 1'b0;
        end else begin
            r_irqs.irq_software <= r_msip;
            r_irqs.irq_timer    <= w_timer_hit;
            r_irqs.irq_external <= irq_ext_i;
            r_irqs.irq_fast     <= r_fast_pend & r_fast_en;
            r_irq_nm            <= r_nmi;
        end
    end

    assign irqs_o   = r_irqs;
    assign irq_nm_o = r_irq_nm;

endmodule

// File: tb/tb_ibex_irq_gen.sv
// Self-checking bench for ibex_irq_gen: register-access vector table,
// directed timer/fast/NMI/reset sequences, then randomized traffic
// against a behavioural model.
module tb_ibex_irq_gen;
    import ibex_irq_gen_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        tick_i;
    logic        irq_ext_i;
    logic [14:0] irq_fast_src_i;
    logic        irq_nm_src_i;
    irqs_t       irqs_o;
    logic        irq_nm_o;
    logic [17:0] irqs_bits;

    assign irqs_bits = irqs_o;

    ibex_irq_gen #(
        .RegAddrW    (6),
        .TimerEnRst  (1'b0),
        .FastEdgeRst (15'h0)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .tick_i         (tick_i),
        .irq_ext_i      (irq_ext_i),
        .irq_fast_src_i (irq_fast_src_i),
        .irq_nm_src_i   (irq_nm_src_i),
        .irqs_o         (irqs_o),
        .irq_nm_o       (irq_nm_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] rd;
    logic        er;
    int          first;

    // Reference model state.
    logic [63:0] m_mtime, m_cmp;
    logic        m_msip, m_ten, m_nmi, m_nmq;
    logic [14:0] m_pend, m_edge, m_en, m_srcq;
    logic        e_valid, e_err, e_nm;
    logic [31:0] e_rdata;
    logic [17:0] e_irqs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic bus_idle();
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
    endtask

    task automatic do_reset();
        bus_idle();
        tick_i         = 1'b0;
        irq_ext_i      = 1'b0;
        irq_fast_src_i = 15'h0;
        irq_nm_src_i   = 1'b0;
        rst_ni         = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    // One bus transaction; response sampled one cycle after the request.
    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        data_be_i    = be;
        step();
        bus_idle();
        chk("rvalid", 64'(data_rvalid_o), 64'd1);
        rdata = data_rdata_o;
        err   = data_err_o;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        logic        e;
        bus(1'b1, addr, wdata, 4'hF, d, e);
        chk($sformatf("wr_err_%h", addr), 64'(e), 64'd0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        bus(1'b0, addr, 32'h0, 4'hF, d, e);
        chk({name, "_rdata"}, 64'(d), 64'(exp));
        chk({name, "_err"}, 64'(e), 64'd0);
    endtask

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp   = '1;
        m_msip  = 1'b0;
        m_ten   = 1'b0;
        m_nmi   = 1'b0;
        m_nmq   = 1'b0;
        m_pend  = 15'h0;
        m_edge  = 15'h0;
        m_en    = 15'h0;
        m_srcq  = 15'h0;
    endtask

    // Computes the outputs expected after the next edge and advances the model.
    task automatic model_step();
        logic [31:0] view [16];
        int          w;
        logic        wrok;
        logic [14:0] clr;
        logic        nclr;
        logic        mt_wr;
        logic [63:0] n_mtime;
        logic [14:0] n_pend;
        w = int'(data_addr_i[5:2]);
        for (int k = 0; k < 16; k++) view[k] = 32'h0;
        view[0] = {31'd0, m_msip};
        view[1] = {31'd0, m_ten};
        view[2] = m_mtime[31:0];
        view[3] = m_mtime[63:32];
        view[4] = m_cmp[31:0];
        view[5] = m_cmp[63:32];
        view[6] = {17'd0, m_pend};
        view[7] = {17'd0, m_edge};
        view[8] = {17'd0, m_en};
        view[9] = {31'd0, m_nmi};
        e_valid = data_req_i;
        e_err   = data_req_i && ((w > 9) || (data_we_i && (data_be_i != 4'hF)));
        e_rdata = (data_req_i && !data_we_i && !e_err) ? view[w] : 32'h0;
        e_irqs  = {m_msip, (m_mtime >= m_cmp), irq_ext_i, m_pend & m_en};
        e_nm    = m_nmi;

        wrok    = data_req_i && data_we_i && !e_err;
        clr     = 15'h0;
        nclr    = 1'b0;
        mt_wr   = 1'b0;
        n_mtime = m_mtime;
        if (wrok) begin
            case (w)
                0: m_msip = data_wdata_i[0];
                1: m_ten  = data_wdata_i[0];
                2: begin n_mtime[31:0]  = data_wdata_i; mt_wr = 1'b1; end
                3: begin n_mtime[63:32] = data_wdata_i; mt_wr = 1'b1; end
                4: m_cmp[31:0]  = data_wdata_i;
                5: m_cmp[63:32] = data_wdata_i;
                6: clr  = data_wdata_i[14:0];
                9: nclr = data_wdata_i[0];
                default: ;
            endcase
        end
        if (!mt_wr && tick_i && view[1][0]) n_mtime = m_mtime + 64'd1;
        m_mtime = n_mtime;
        for (int i = 0; i < 15; i++) begin
            if (m_edge[i])
                n_pend[i] = (m_pend[i] && !clr[i]) || (irq_fast_src_i[i] && !m_srcq[i]);
            else
                n_pend[i] = irq_fast_src_i[i];
        end
        m_pend = n_pend;
        m_nmi  = (m_nmi && !nclr) || (irq_nm_src_i && !m_nmq);
        m_nmq  = irq_nm_src_i;
        m_srcq = irq_fast_src_i;
        if (wrok && (w == 7)) m_edge = data_wdata_i[14:0];
        if (wrok && (w == 8)) m_en   = data_wdata_i[14:0];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_i);
        do_reset();
        chk("reset_rvalid", 64'(data_rvalid_o), 64'd0);
        chk("reset_irqs", 64'(irqs_bits), 64'd0);
        chk("reset_nm", 64'(irq_nm_o), 64'd0);

        // Register access vectors applied from reset.
        vecs.push_back('{1'b0, 32'h10, 32'h0,        4'hF, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b0, 32'h14, 32'h0,        4'hF, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b0, 32'h04, 32'h0,        4'hF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h08, 32'h0,        4'hF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h0C, 32'h0,        4'hF, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 32'h00, 32'h1,        4'h3, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h00, 32'h0,        4'hF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h3C, 32'h0,        4'hF, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h28, 32'h0,        4'hF, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h3C, 32'h1,        4'hF, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h00, 32'h0,        4'h1, 32'h1,         1'b0});
        vecs.push_back('{1'b1, 32'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h1C, 32'h0,        4'hF, 32'h7FFF,      1'b0});
        vecs.push_back('{1'b1, 32'h1C, 32'h0,        4'hF, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 32'h24, 32'h1,        4'hF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h24, 32'h0,        4'hF, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 32'h08, 32'h1234_5678, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h08, 32'h0,        4'hF, 32'h1234_5678, 1'b0});
        vecs.push_back('{1'b1, 32'h0C, 32'hABCD_0000, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0C, 32'h0,        4'hF, 32'hABCD_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h4C, 32'h0,        4'hF, 32'hABCD_0000, 1'b0});
        vecs.push_back('{1'b1, 32'h20, 32'hFFFF_0003, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h20, 32'h0,        4'hF, 32'h3,         1'b0});
        vecs.push_back('{1'b1, 32'h08, 32'h0,        4'h7, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h08, 32'h0,        4'hF, 32'h1234_5678, 1'b0});
        foreach (vecs[i]) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er);
            chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
        end
        step();
        chk("msip_irq", 64'(irqs_o.irq_software), 64'd1);

        // Timer rise with continuous ticks and compare value 5.
        do_reset();
        wr(32'h10, 32'd5);
        wr(32'h14, 32'd0);
        wr(32'h04, 32'd1);
        tick_i = 1'b1;
        first  = 0;
        for (int n = 1; n <= 20 && first == 0; n++) begin
            step();
            if (irqs_o.irq_timer) first = n;
        end
        tick_i = 1'b0;
        chk("timer_rise_cycle", 64'(first), 64'd6);
        rd_chk("mtime_after_rise", 32'h08, 32'd6);

        // 64-bit wrap, then compare of zero.
        wr(32'h08, 32'hFFFF_FFFF);
        wr(32'h0C, 32'hFFFF_FFFF);
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        rd_chk("wrap_lo", 32'h08, 32'h0);
        rd_chk("wrap_hi", 32'h0C, 32'h0);
        chk("timer_low_after_wrap", 64'(irqs_o.irq_timer), 64'd0);
        wr(32'h10, 32'h0);
        step();
        step();
        chk("timer_cmp_zero", 64'(irqs_o.irq_timer), 64'd1);

        // Fast edge mode on source 0.
        do_reset();
        wr(32'h1C, 32'h1);
        wr(32'h20, 32'h1);
        irq_fast_src_i = 15'h1;
        step();
        irq_fast_src_i = 15'h0;
        step();
        step();
        chk("fast0_irq", 64'(irqs_o.irq_fast), 64'h1);
        rd_chk("fast0_pend", 32'h18, 32'h1);
        irq_fast_src_i = 15'h1;
        wr(32'h18, 32'h1);
        irq_fast_src_i = 15'h0;
        rd_chk("fast0_set_wins", 32'h18, 32'h1);
        wr(32'h18, 32'h1);
        rd_chk("fast0_cleared", 32'h18, 32'h0);
        chk("fast0_irq_cleared", 64'(irqs_o.irq_fast), 64'h0);

        // Fast level mode on source 3.
        irq_fast_src_i = 15'h8;
        step();
        step();
        rd_chk("fast3_pend", 32'h18, 32'h8);
        chk("fast3_masked", 64'(irqs_o.irq_fast), 64'h0);
        wr(32'h20, 32'h9);
        step();
        chk("fast3_enabled", 64'(irqs_o.irq_fast), 64'h8);
        wr(32'h18, 32'h8);
        rd_chk("fast3_w1c_ignored", 32'h18, 32'h8);
        irq_fast_src_i = 15'h0;
        step();
        step();
        chk("fast3_dropped", 64'(irqs_o.irq_fast), 64'h0);

        // NMI latch.
        irq_nm_src_i = 1'b1;
        step();
        irq_nm_src_i = 1'b0;
        step();
        step();
        chk("nmi_out", 64'(irq_nm_o), 64'd1);
        rd_chk("nmi_latched", 32'h24, 32'h1);
        irq_nm_src_i = 1'b1;
        wr(32'h24, 32'h1);
        irq_nm_src_i = 1'b0;
        rd_chk("nmi_set_wins", 32'h24, 32'h1);
        wr(32'h24, 32'h1);
        rd_chk("nmi_cleared", 32'h24, 32'h0);
        step();
        chk("nmi_out_cleared", 64'(irq_nm_o), 64'd0);

        // External level passthrough.
        irq_ext_i = 1'b1;
        step();
        chk("ext_high", 64'(irqs_o.irq_external), 64'd1);
        irq_ext_i = 1'b0;
        step();
        chk("ext_low", 64'(irqs_o.irq_external), 64'd0);

        // Reset during a request drops the response.
        wr(32'h00, 32'h1);
        step();
        data_req_i  = 1'b1;
        data_addr_i = 32'h10;
        rst_ni      = 1'b0;
        step();
        chk("rst_drops_rvalid", 64'(data_rvalid_o), 64'd0);
        chk("rst_clears_irqs", 64'(irqs_bits), 64'd0);
        bus_idle();
        rst_ni = 1'b1;
        step();
        chk("rst_idle_rvalid", 64'(data_rvalid_o), 64'd0);
        rd_chk("rst_msip", 32'h00, 32'h0);

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            data_req_i   = ($urandom_range(0, 1) == 1);
            data_we_i    = ($urandom_range(0, 1) == 1);
            data_addr_i  = ($urandom & 32'hFFFF_FFC0) | 32'(($urandom_range(0, 11)) << 2);
            data_be_i    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            data_wdata_i = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
            tick_i       = ($urandom_range(0, 1) == 1);
            irq_ext_i    = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) irq_fast_src_i = 15'($urandom);
            if ($urandom_range(0, 3) == 0) irq_nm_src_i = ($urandom_range(0, 1) == 1);
            model_step();
            step();
            chk("rnd_rvalid", 64'(data_rvalid_o), 64'(e_valid));
            chk("rnd_err", 64'(data_err_o), 64'(e_err));
            chk("rnd_rdata", 64'(data_rdata_o), 64'(e_rdata));
            chk("rnd_irqs", 64'(irqs_bits), 64'(e_irqs));
            chk("rnd_nm", 64'(irq_nm_o), 64'(e_nm));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
